// File: rtl/exc_flow_ctrl_pkg.sv
// Shared encodings for the exception/interrupt sequencer:
// FSM states, ExcCodes, CP0 register numbers, address map.
package exc_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_ERET = 2'd2
  } state_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO_DEF    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_DEF    = 32'h0000_6ffc;

endpackage

// File: rtl/exc_flow_ctrl_fetch_check.sv
// Fetch-address checker: flags misaligned or out-of-text f_pc as AdEL.
// Ports: f_pc (fetch PC) in, f_exc (4 = AdEL, else 0) out.
module exc_fetch_check
  import exc_flow_ctrl_pkg::*;
#(
  parameter logic [31:0] TEXT_LO = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI = TEXT_HI_DEF
) (
  input  logic [31:0] f_pc,
  output logic [4:0]  f_exc
);

  logic bad;

  assign bad = (f_pc[1:0] != 2'b00)
             | (f_pc < TEXT_LO)
             | (f_pc > TEXT_HI);

  assign f_exc = bad ? EXC_ADEL : EXC_INT;

endmodule

// File: rtl/exc_flow_ctrl.sv
// Exception/interrupt sequencer between M stage and CP0.
// Ports: pipeline M/E/D/F status in, CP0 controls out, flush/redirect/stall out.
module exc_flow_ctrl
  import exc_flow_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] TEXT_LO    = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI    = TEXT_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_pc,
  output logic [4:0]  f_exc,
  input  logic        d_eret,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_mtc0_epc,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc,
  input  logic        m_eret,
  input  logic        m_mtc0,
  input  logic [4:0]  m_cp0_addr,
  input  logic [5:0]  hw_int,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  output logic [31:0] cp0_vpc,
  output logic        cp0_bd,
  output logic [4:0]  cp0_exc,
  output logic [5:0]  cp0_hwint,
  output logic        cp0_exl_clr,
  output logic        cp0_wr_en,
  output logic        flush,
  output logic        npc_sel,
  output logic [31:0] npc,
  output logic        stall_d,
  output logic [1:0]  state
);

  state_e      state_q, state_d;
  logic [31:0] target, resume_pc;
  logic        take_exc, take_eret;

  exc_fetch_check #(
    .TEXT_LO (TEXT_LO),
    .TEXT_HI (TEXT_HI)
  ) u_fetch (
    .f_pc  (f_pc),
    .f_exc (f_exc)
  );

  // Oldest live instruction is the victim; with an empty M/E
  // the interrupt resumes at the next not-yet-retired PC.
  assign cp0_vpc = m_valid ? m_pc
                 : e_valid ? e_pc
                 : resume_pc;
  assign cp0_bd  = m_bd & m_valid;
  assign state   = state_q;

  always_comb begin
    state_d     = ST_RUN;
    take_exc    = 1'b0;
    take_eret   = 1'b0;
    cp0_exc     = EXC_INT;
    cp0_hwint   = 6'd0;
    cp0_exl_clr = 1'b0;
    cp0_wr_en   = 1'b0;
    flush       = 1'b0;
    npc_sel     = 1'b0;
    npc         = 32'd0;
    stall_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        cp0_exc   = m_valid ? m_exc : EXC_INT;
        cp0_hwint = hw_int;
        cp0_wr_en = m_mtc0 & ~cp0_req;
        stall_d   = d_eret
                  & (e_mtc0_epc
                  | (m_mtc0 & (m_cp0_addr == CP0_EPC)));
        // Req wins over eret: the eret is squashed
        // and becomes the victim instead.
        if (cp0_req) begin
          take_exc = 1'b1;
          flush    = 1'b1;
          state_d  = ST_TRAP;
        end else if (m_eret & m_valid) begin
          take_eret   = 1'b1;
          flush       = 1'b1;
          cp0_exl_clr = 1'b1;
          state_d     = ST_ERET;
        end
      end
      ST_TRAP, ST_ERET: begin
        npc_sel = 1'b1;
        npc     = target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      target    <= 32'd0;
      resume_pc <= TEXT_LO;
    end else begin
      state_q <= state_d;
      if (take_exc)
        target <= HANDLER_PC;
      else if (take_eret)
        target <= cp0_epc;
      if (npc_sel)
        resume_pc <= npc;
      else if (m_valid & ~flush)
        resume_pc <= m_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_exc_flow_ctrl.sv
// Scoreboard bench for exc_flow_ctrl: expectations queued per cycle
// when stimulus is driven, popped and compared mid-cycle.
module tb_exc_flow_ctrl;

  typedef enum int {
    S_FEXC, S_VPC, S_BD, S_EXC, S_HWINT, S_EXLCLR,
    S_WREN, S_FLUSH, S_NPCSEL, S_NPC, S_STALL, S_STATE
  } sig_e;

  typedef struct {
    int          due;
    sig_e        sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic        clk = 1'b1;
  logic        reset;
  logic [31:0] f_pc;
  logic [4:0]  f_exc;
  logic        d_eret;
  logic        e_valid;
  logic [31:0] e_pc;
  logic        e_mtc0_epc;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic        m_eret;
  logic        m_mtc0;
  logic [4:0]  m_cp0_addr;
  logic [5:0]  hw_int;
  logic        cp0_req;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_vpc;
  logic        cp0_bd;
  logic [4:0]  cp0_exc;
  logic [5:0]  cp0_hwint;
  logic        cp0_exl_clr;
  logic        cp0_wr_en;
  logic        flush;
  logic        npc_sel;
  logic [31:0] npc;
  logic        stall_d;
  logic [1:0]  state;

  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t sb[$];

  always #5 clk = ~clk;

  exc_flow_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .f_pc        (f_pc),
    .f_exc       (f_exc),
    .d_eret      (d_eret),
    .e_valid     (e_valid),
    .e_pc        (e_pc),
    .e_mtc0_epc  (e_mtc0_epc),
    .m_valid     (m_valid),
    .m_pc        (m_pc),
    .m_bd        (m_bd),
    .m_exc       (m_exc),
    .m_eret      (m_eret),
    .m_mtc0      (m_mtc0),
    .m_cp0_addr  (m_cp0_addr),
    .hw_int      (hw_int),
    .cp0_req     (cp0_req),
    .cp0_epc     (cp0_epc),
    .cp0_vpc     (cp0_vpc),
    .cp0_bd      (cp0_bd),
    .cp0_exc     (cp0_exc),
    .cp0_hwint   (cp0_hwint),
    .cp0_exl_clr (cp0_exl_clr),
    .cp0_wr_en   (cp0_wr_en),
    .flush       (flush),
    .npc_sel     (npc_sel),
    .npc         (npc),
    .stall_d     (stall_d),
    .state       (state)
  );

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_FEXC:   return {27'd0, f_exc};
      S_VPC:    return cp0_vpc;
      S_BD:     return {31'd0, cp0_bd};
      S_EXC:    return {27'd0, cp0_exc};
      S_HWINT:  return {26'd0, cp0_hwint};
      S_EXLCLR: return {31'd0, cp0_exl_clr};
      S_WREN:   return {31'd0, cp0_wr_en};
      S_FLUSH:  return {31'd0, flush};
      S_NPCSEL: return {31'd0, npc_sel};
      S_NPC:    return npc;
      S_STALL:  return {31'd0, stall_d};
      default:  return {30'd0, state};
    endcase
  endfunction

  task automatic expect_at(input int off, input sig_e s,
                           input logic [31:0] v,
                           input string tag);
    exp_t e;
    e.due = cyc + off;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check_eq(sb[i].tag, observe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    reset      = 1'b1;
    f_pc       = 32'h3000;
    d_eret     = 1'b0;
    e_valid    = 1'b0;
    e_pc       = 32'd0;
    e_mtc0_epc = 1'b0;
    m_valid    = 1'b0;
    m_pc       = 32'd0;
    m_bd       = 1'b0;
    m_exc      = 5'd0;
    m_eret     = 1'b0;
    m_mtc0     = 1'b0;
    m_cp0_addr = 5'd0;
    hw_int     = 6'd0;
    cp0_req    = 1'b0;
    cp0_epc    = 32'd0;
  endtask

  initial begin
    cyc   = 0;
    n_chk = 0;
    n_err = 0;

    idle(); reset = 1'b0;
    tick();
    idle(); reset = 1'b0;
    expect_at(0, S_STATE, 0, "rst_state");
    expect_at(0, S_NPCSEL, 0, "rst_npcsel");
    expect_at(0, S_FLUSH, 0, "rst_flush");
    expect_at(0, S_EXLCLR, 0, "rst_exlclr");
    expect_at(0, S_VPC, 32'h3000, "rst_vpc");
    tick();

    idle(); f_pc = 32'h3002;
    expect_at(0, S_FEXC, 4, "fexc_misal");
    tick();
    idle(); f_pc = 32'h2ffc;
    expect_at(0, S_FEXC, 4, "fexc_low");
    tick();
    idle(); f_pc = 32'h3004;
    expect_at(0, S_FEXC, 0, "fexc_ok");
    tick();
    idle(); f_pc = 32'h7000;
    expect_at(0, S_FEXC, 4, "fexc_high");
    tick();
    idle(); f_pc = 32'h6ffc;
    expect_at(0, S_FEXC, 0, "fexc_top");
    tick();

    idle();
    m_valid = 1'b1; m_pc = 32'h3010; m_exc = 5'd12;
    m_mtc0 = 1'b1; cp0_req = 1'b1;
    expect_at(0, S_FLUSH, 1, "ov_flush");
    expect_at(0, S_VPC, 32'h3010, "ov_vpc");
    expect_at(0, S_EXC, 12, "ov_exc");
    expect_at(0, S_WREN, 0, "ov_wren");
    expect_at(1, S_NPCSEL, 1, "ov_npcsel");
    expect_at(1, S_NPC, 32'h4180, "ov_npc");
    expect_at(1, S_STATE, 1, "ov_trap");
    expect_at(1, S_FLUSH, 0, "ov_flush1");
    expect_at(2, S_STATE, 0, "ov_run");
    expect_at(2, S_NPCSEL, 0, "ov_npcsel2");
    tick();
    idle();
    hw_int = 6'h3f; m_valid = 1'b1; m_exc = 5'd12; m_mtc0 = 1'b1;
    d_eret = 1'b1; e_mtc0_epc = 1'b1;
    expect_at(0, S_EXC, 0, "trap_exc");
    expect_at(0, S_HWINT, 0, "trap_hwint");
    expect_at(0, S_WREN, 0, "trap_wren");
    expect_at(0, S_STALL, 0, "trap_stall");
    tick();
    idle();
    tick();

    idle();
    m_valid = 1'b1; m_pc = 32'h301c; m_mtc0 = 1'b1; m_bd = 1'b1;
    expect_at(0, S_WREN, 1, "run_wren");
    expect_at(0, S_FLUSH, 0, "run_flush");
    expect_at(0, S_BD, 1, "run_bd");
    tick();
    idle(); hw_int = 6'b000100; cp0_req = 1'b1; m_bd = 1'b1;
    expect_at(0, S_VPC, 32'h3020, "int_vpc");
    expect_at(0, S_EXC, 0, "int_exc");
    expect_at(0, S_HWINT, 4, "int_hwint");
    expect_at(0, S_FLUSH, 1, "int_flush");
    expect_at(0, S_BD, 0, "int_bd");
    expect_at(1, S_NPC, 32'h4180, "int_npc");
    tick();
    idle();
    tick();

    idle(); e_valid = 1'b1; e_pc = 32'h3abc;
    expect_at(0, S_VPC, 32'h3abc, "e_vpc");
    tick();

    idle();
    m_valid = 1'b1; m_eret = 1'b1; m_pc = 32'h3040; cp0_epc = 32'h3044;
    expect_at(0, S_FLUSH, 1, "eret_flush");
    expect_at(0, S_EXLCLR, 1, "eret_exlclr");
    expect_at(1, S_NPCSEL, 1, "eret_npcsel");
    expect_at(1, S_NPC, 32'h3044, "eret_npc");
    expect_at(1, S_STATE, 2, "eret_state");
    expect_at(1, S_EXLCLR, 0, "eret_exlclr1");
    tick();
    idle();
    tick();
    idle(); cp0_req = 1'b1;
    expect_at(0, S_VPC, 32'h3044, "b2b_vpc");
    expect_at(1, S_NPC, 32'h4180, "b2b_npc");
    expect_at(1, S_STATE, 1, "b2b_state");
    tick();
    idle();
    tick();

    idle();
    m_valid = 1'b1; m_eret = 1'b1; cp0_epc = 32'h3044; cp0_req = 1'b1;
    expect_at(0, S_EXLCLR, 0, "squash_exlclr");
    expect_at(0, S_FLUSH, 1, "squash_flush");
    expect_at(1, S_NPC, 32'h4180, "squash_npc");
    expect_at(1, S_STATE, 1, "squash_state");
    tick();
    idle();
    tick();

    idle(); d_eret = 1'b1; e_mtc0_epc = 1'b1;
    expect_at(0, S_STALL, 1, "stall_e");
    tick();
    idle(); d_eret = 1'b1; m_mtc0 = 1'b1; m_cp0_addr = 5'd14;
    expect_at(0, S_STALL, 1, "stall_m");
    tick();
    idle(); d_eret = 1'b1; m_mtc0 = 1'b1; m_cp0_addr = 5'd13;
    expect_at(0, S_STALL, 0, "stall_off");
    tick();

    idle(); cp0_req = 1'b1;
    expect_at(1, S_STATE, 1, "rt_trap");
    expect_at(1, S_NPCSEL, 1, "rt_npcsel");
    tick();
    idle(); reset = 1'b0;
    expect_at(1, S_STATE, 0, "rt_state");
    expect_at(1, S_NPCSEL, 0, "rt_npcsel0");
    expect_at(1, S_FLUSH, 0, "rt_flush");
    expect_at(1, S_EXLCLR, 0, "rt_exlclr");
    expect_at(1, S_NPC, 0, "rt_npc");
    tick();
    idle();
    tick();
    tick();

    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/exc_flow_ctrl.md
Name: exc_flow_ctrl

Overview:
- Exception/interrupt sequencer sitting between the pipeline's M stage and CP0.
- Drives CP0's victim PC, BD, ExcCode, gated HWInt and EXL-clear inputs; consumes CP0's Req and EPC.
- Drives the pipeline flush, next-PC redirect (handler entry or EPC on eret) and the D-stage eret/mtc0-EPC hazard stall.
- Generates fetch-address exceptions (AdEL) for the F stage.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception handler entry address.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- f_pc  in  32  fetch PC.
- f_exc  out  5  fetch exception code: 4 (AdEL) or 0.
- d_eret  in  1  eret in D.
- e_valid  in  1  E holds a real instruction.
- e_pc  in  32  E-stage PC.
- e_mtc0_epc  in  1  E is mtc0 to CP0 reg 14.
- m_valid  in  1  M holds a real instruction.
- m_pc  in  32  M-stage PC.
- m_bd  in  1  M instruction is in a delay slot.
- m_exc  in  5  accumulated exception code at M, 0 = none.
- m_eret  in  1  eret in M.
- m_mtc0  in  1  mtc0 in M.
- m_cp0_addr  in  5  CP0 register number of the M-stage mtc0.
- hw_int  in  6  raw hardware interrupt lines.
- cp0_req  in  1  CP0 Req.
- cp0_epc  in  32  CP0 EPC.
- cp0_vpc  out  32  victim PC to CP0.
- cp0_bd  out  1  BD to CP0.
- cp0_exc  out  5  ExcCode to CP0.
- cp0_hwint  out  6  gated interrupt lines to CP0.
- cp0_exl_clr  out  1  EXL clear to CP0.
- cp0_wr_en  out  1  mtc0 write enable to CP0.
- flush  out  1  kill F/D/E/M instructions.
- npc_sel  out  1  1 = take npc.
- npc  out  32  redirect target.
- stall_d  out  1  hold F/D, bubble into E.
- state  out  2  FSM state, debug.

Behaviour:
- FSM states: RUN=0, TRAP=1, ERET=2. Internal registers: state, target[31:0], resume_pc[31:0].
- Reset (reset==0 at clk edge):
  - state=RUN, target=0, resume_pc=TEXT_LO.
  - All registered-derived outputs deassert in the following cycle: flush=0, npc_sel=0, cp0_exl_clr=0.
  - Reset mid-TRAP/ERET abandons the redirect.
- f_exc:
  - Combinational, 4 when f_pc[1:0]!=0 or f_pc<TEXT_LO or f_pc>TEXT_HI; otherwise 0.
  - Independent of state.
- Victim PC:
  - cp0_vpc = m_pc if m_valid, else e_pc if e_valid, else resume_pc.
  - cp0_bd = m_bd & m_valid.
  - resume_pc <= m_pc+4 whenever m_valid & !flush; resume_pc <= npc whenever npc_sel.
- RUN state:
  - cp0_exc = m_valid ? m_exc : 0.
  - cp0_hwint = hw_int.
  - cp0_wr_en = m_mtc0 & !cp0_req.
- RUN with cp0_req=1:
  - flush=1, cp0_wr_en=0, target<=HANDLER_PC, next state TRAP.
  - cp0_req beats m_eret in the same cycle: the eret is squashed and its PC becomes EPC.
- RUN with cp0_req=0 and m_eret & m_valid:
  - flush=1, cp0_exl_clr=1, target<=cp0_epc, next state ERET.
- TRAP and ERET (one cycle each, then RUN):
  - npc_sel=1, npc=target, flush=0.
  - cp0_exc=0, cp0_hwint=0, cp0_wr_en=0, so no nested Req is possible.
- npc_sel=0 and npc=0 in RUN.
- stall_d = d_eret & (e_mtc0_epc | (m_mtc0 & m_cp0_addr==14)) in RUN only; forced 0 in TRAP/ERET.
- Latency:
  - Exception or eret at M in cycle N gives flush in N and redirect in N+1.
  - The first handler or EPC instruction is fetched in N+1.
- Back-to-back case: an eret followed by a pending interrupt is taken once back in RUN, with EPC = resume_pc = eret target.

Decomposition:
- Shared package: state encodings; ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12); CP0 register numbers (SR=12, CAUSE=13, EPC=14); HANDLER_PC.
- One natural sub-module: exc_fetch_check, the f_pc range/alignment comparator producing f_exc.

Test Plan:
- f_pc=32'h3002, then 32'h2ffc, then 32'h3004 -> f_exc = 4, 4, 0.
- m_valid=1, m_pc=32'h3010, m_exc=12 (Ov), cp0_req=1 at cycle N:
  - cycle N: flush=1, cp0_vpc=32'h3010, cp0_exc=12, cp0_wr_en=0.
  - cycle N+1: npc_sel=1, npc=32'h4180, state=TRAP.
  - cycle N+2: state=RUN.
- m_valid=0, e_valid=0, resume_pc=32'h3020, hw_int=6'b000100, cp0_req=1 -> cp0_vpc=32'h3020, cp0_exc=0, redirect to 32'h4180.
- m_eret=1, cp0_epc=32'h3044 -> flush=1 and cp0_exl_clr=1, then npc_sel=1 with npc=32'h3044; with cp0_req=1 in the same cycle, redirect goes to 32'h4180 and cp0_exl_clr=0.
- d_eret=1 with e_mtc0_epc=1 -> stall_d=1 for that cycle; next cycle with m_mtc0=1, m_cp0_addr=14 -> stall_d=1; the cycle after -> 0.
- reset=0 asserted during TRAP -> next cycle state=RUN, npc_sel=0, flush=0, cp0_exl_clr=0.
